// File: rtl/timer_countdown_pkg.sv
// Shared definitions for the microwave cook timer: FSM state encodings and
// BCD digit limits used by the top level and the digit cells.
package timer_countdown_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } timer_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/timer_countdown_bcd_digit_down.sv
// One BCD digit of the countdown. Loads a shifted-in key digit, decrements
// on request and wraps to WRAP_VAL with a borrow to the next digit.
module bcd_digit_down
  import timer_countdown_pkg::*;
#(
  parameter logic [3:0] WRAP_VAL = BCD_MAX
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;

  // Digit register: reset, then clear, then key load, then decrement.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the borrow chain sees a consistent snapshot.
    if (!resetn) begin
      r_digit <= 4'd0;
    end else if (clr) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= load_val;
    end else if (dec) begin
      // Values above WRAP_VAL (e.g. sec_tens = 7) just count down normally;
      // the wrap value only matters on borrow.
      r_digit <= (r_digit == 4'd0) ? WRAP_VAL : r_digit - 4'd1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec && (r_digit == 4'd0);

endmodule

// File: rtl/timer_countdown.sv
// Microwave cook timer: shifts keypad digits into an MM:SS display, counts
// down once per TICK_DIV cycles while the magnetron is on, and flags zero.
module timer_countdown
  import timer_countdown_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       mag_on,
  output logic       timer_done,
  output logic       done_pulse,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  timer_state_t  r_state;
  timer_state_t  w_state_next;
  logic          r_done_pulse;
  logic          w_done_next;
  logic [PW-1:0] r_presc;

  logic [3:0] w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
  logic       w_borrow_so, w_borrow_st, w_borrow_mo, w_borrow_mt;
  logic       w_key_accept;
  logic       w_key_nonzero;
  logic       w_count_en;
  logic       w_tick;
  logic       w_last_tick;

  // Keys are only taken while the magnetron is off; a key and a tick can
  // therefore never act on the same edge.
  assign w_key_accept  = key_valid && !mag_on && (key_digit <= BCD_MAX);
  assign w_key_nonzero = (w_min_ones | w_sec_tens | w_sec_ones | key_digit) != 4'd0;
  assign w_count_en    = mag_on && (r_state != ST_ZERO);
  assign w_tick        = w_count_en && (r_presc == PRESC_LAST);
  assign w_last_tick   = w_tick &&
                         ({w_min_tens, w_min_ones, w_sec_tens, w_sec_ones} == 16'h0001);

  // Prescaler: holds while paused so a partial second survives mag_on low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (!clearn) begin
      r_presc <= '0;
    end else if (w_key_accept) begin
      r_presc <= '0;
    end else if (w_count_en) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  bcd_digit_down #(.WRAP_VAL(BCD_MAX)) u_sec_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (!clearn),
    .load       (w_key_accept),
    .load_val   (key_digit),
    .dec        (w_tick),
    .digit      (w_sec_ones),
    .borrow_out (w_borrow_so)
  );

  bcd_digit_down #(.WRAP_VAL(SEC_TENS_MAX)) u_sec_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (!clearn),
    .load       (w_key_accept),
    .load_val   (w_sec_ones),
    .dec        (w_borrow_so),
    .digit      (w_sec_tens),
    .borrow_out (w_borrow_st)
  );

  bcd_digit_down #(.WRAP_VAL(BCD_MAX)) u_min_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (!clearn),
    .load       (w_key_accept),
    .load_val   (w_sec_tens),
    .dec        (w_borrow_st),
    .digit      (w_min_ones),
    .borrow_out (w_borrow_mo)
  );

  bcd_digit_down #(.WRAP_VAL(BCD_MAX)) u_min_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (!clearn),
    .load       (w_key_accept),
    .load_val   (w_min_ones),
    .dec        (w_borrow_mo),
    .digit      (w_min_tens),
    .borrow_out (w_borrow_mt)
  );

  // FSM state and done strobe registers.
  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      r_state      <= ST_ZERO;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_done_pulse <= w_done_next;
    end
  end

  // Next-state and done-strobe decode.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (w_key_accept) begin
      w_state_next = w_key_nonzero ? ST_ARMED : ST_ZERO;
    end else if (w_last_tick) begin
      w_state_next = ST_ZERO;
      w_done_next  = 1'b1;
    end else if (r_state != ST_ZERO) begin
      w_state_next = mag_on ? ST_RUN : ST_ARMED;
    end
  end

  // The min_tens borrow can only fire when counting from 0:00, which ZERO
  // never does; it is left unused.
  logic w_unused;
  assign w_unused = w_borrow_mt;

  assign min_tens   = w_min_tens;
  assign min_ones   = w_min_ones;
  assign sec_tens   = w_sec_tens;
  assign sec_ones   = w_sec_ones;
  assign timer_done = ({w_min_tens, w_min_ones, w_sec_tens, w_sec_ones} == 16'h0000);
  assign done_pulse = r_done_pulse;
  assign state      = r_state;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with TICK_DIV = 4.
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clearn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       mag_on = 1'b0;
  logic       timer_done, done_pulse;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic [15:0] w_time;

  int n_pass  = 0;
  int n_total = 0;

  timer_countdown #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign w_time = {min_tens, min_ones, sec_tens, sec_ones};

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic do_clear();
    mag_on = 1'b0;
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(2);
    n_total++;
    if (w_time !== 16'h0000 || timer_done !== 1'b1 || state !== 2'b00 || done_pulse !== 1'b0)
      $display("FAIL reset: time=%h done=%b state=%b pulse=%b, want 0000/1/00/0",
               w_time, timer_done, state, done_pulse);
    else n_pass++;
    resetn = 1'b1;
    step(1);
  endtask

  task automatic test_entry_rollover();
    press(4'd1); press(4'd0); press(4'd5);
    n_total++;
    if (w_time !== 16'h0105 || state !== 2'b01 || timer_done !== 1'b0)
      $display("FAIL entry: time=%h state=%b done=%b, want 0105/01/0", w_time, state, timer_done);
    else n_pass++;
    mag_on = 1'b1;
    step(20);
    n_total++;
    if (w_time !== 16'h0100 || state !== 2'b10)
      $display("FAIL run_5ticks: time=%h state=%b, want 0100/10", w_time, state);
    else n_pass++;
    step(4);
    n_total++;
    if (w_time !== 16'h0059)
      $display("FAIL rollover: time=%h, want 0059", w_time);
    else n_pass++;
    mag_on = 1'b0;
    step(1);
    n_total++;
    if (state !== 2'b01)
      $display("FAIL run_to_armed: state=%b, want 01", state);
    else n_pass++;
    do_clear();
    n_total++;
    if (w_time !== 16'h0000 || state !== 2'b00)
      $display("FAIL clear: time=%h state=%b, want 0000/00", w_time, state);
    else n_pass++;
  endtask

  task automatic test_countdown_done();
    press(4'd2);
    mag_on = 1'b1;
    step(4);
    n_total++;
    if (w_time !== 16'h0001 || done_pulse !== 1'b0)
      $display("FAIL cd_first_tick: time=%h pulse=%b, want 0001/0", w_time, done_pulse);
    else n_pass++;
    step(3);
    n_total++;
    if (w_time !== 16'h0001 || done_pulse !== 1'b0)
      $display("FAIL cd_before_done: time=%h pulse=%b, want 0001/0", w_time, done_pulse);
    else n_pass++;
    step(1);
    n_total++;
    if (w_time !== 16'h0000 || done_pulse !== 1'b1 || timer_done !== 1'b1 || state !== 2'b00)
      $display("FAIL cd_done: time=%h pulse=%b done=%b state=%b, want 0000/1/1/00",
               w_time, done_pulse, timer_done, state);
    else n_pass++;
    step(1);
    n_total++;
    if (done_pulse !== 1'b0)
      $display("FAIL cd_pulse_width: pulse=%b, want 0", done_pulse);
    else n_pass++;
    step(8);
    n_total++;
    if (w_time !== 16'h0000 || state !== 2'b00 || done_pulse !== 1'b0)
      $display("FAIL zero_holds: time=%h state=%b pulse=%b, want 0000/00/0",
               w_time, state, done_pulse);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_pause();
    press(4'd3);
    mag_on = 1'b1;
    step(6);
    n_total++;
    if (w_time !== 16'h0002)
      $display("FAIL pause_run: time=%h, want 0002", w_time);
    else n_pass++;
    mag_on = 1'b0;
    step(10);
    n_total++;
    if (w_time !== 16'h0002 || state !== 2'b01)
      $display("FAIL pause_hold: time=%h state=%b, want 0002/01", w_time, state);
    else n_pass++;
    mag_on = 1'b1;
    step(1);
    n_total++;
    if (w_time !== 16'h0002)
      $display("FAIL pause_resume1: time=%h, want 0002", w_time);
    else n_pass++;
    step(1);
    n_total++;
    if (w_time !== 16'h0001)
      $display("FAIL pause_resume2: time=%h, want 0001", w_time);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_ignored_inputs();
    press(4'd4);
    press(4'hA);
    n_total++;
    if (w_time !== 16'h0004)
      $display("FAIL bad_digit: time=%h, want 0004", w_time);
    else n_pass++;
    mag_on = 1'b1;
    press(4'd7);
    n_total++;
    if (w_time !== 16'h0004 || state !== 2'b10)
      $display("FAIL key_while_on: time=%h state=%b, want 0004/10", w_time, state);
    else n_pass++;
    step(3);
    n_total++;
    if (w_time !== 16'h0003)
      $display("FAIL tick_after_key: time=%h, want 0003", w_time);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_clear_vs_tick();
    press(4'd1);
    mag_on = 1'b1;
    step(3);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    mag_on = 1'b0;
    n_total++;
    if (w_time !== 16'h0000 || done_pulse !== 1'b0 || state !== 2'b00)
      $display("FAIL clear_vs_tick: time=%h pulse=%b state=%b, want 0000/0/00",
               w_time, done_pulse, state);
    else n_pass++;
    step(1);
    n_total++;
    if (done_pulse !== 1'b0)
      $display("FAIL clear_no_pulse: pulse=%b, want 0", done_pulse);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    n_total++;
    if (w_time !== 16'h2345 || state !== 2'b01)
      $display("FAIL shift_out: time=%h state=%b, want 2345/01", w_time, state);
    else n_pass++;
    press(4'd0); press(4'd0); press(4'd0); press(4'd0);
    n_total++;
    if (w_time !== 16'h0000 || state !== 2'b00 || timer_done !== 1'b1)
      $display("FAIL shift_to_zero: time=%h state=%b done=%b, want 0000/00/1",
               w_time, state, timer_done);
    else n_pass++;
    press(4'd7); press(4'd5);
    mag_on = 1'b1;
    step(4);
    n_total++;
    if (w_time !== 16'h0074)
      $display("FAIL sec_tens_over5: time=%h, want 0074", w_time);
    else n_pass++;
    do_clear();
    press(4'd1); press(4'd0); press(4'd0);
    mag_on = 1'b1;
    step(4);
    n_total++;
    if (w_time !== 16'h0059)
      $display("FAIL borrow_to_5: time=%h, want 0059", w_time);
    else n_pass++;
    do_clear();
  endtask

  initial begin
    test_reset();
    test_entry_rollover();
    test_countdown_done();
    test_pause();
    test_ignored_inputs();
    test_clear_vs_tick();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
